// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the 4-master round-robin Wishbone arbiter.
// arb = arbiter view, master = requester side, slave = shared slave side.
interface wb_rr_arbiter_if;
    logic [3:0]   m_cyc_i;
    logic [3:0]   m_stb_i;
    logic [3:0]   m_we_i;
    logic [127:0] m_adr_i;
    logic [127:0] m_dat_i;
    logic [15:0]  m_sel_i;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_ack_o;
    logic [3:0]   m_err_o;
    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic         s_cyc_o;
    logic         s_stb_o;
    logic [31:0]  s_dat_i;
    logic         s_ack_i;
    logic [3:0]   gnt_o;

    modport arb (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output gnt_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o, gnt_o
    );

    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// 4-master round-robin Wishbone arbiter with one IDLE cycle between grants.
// Define WB_ARB_TIMEOUT_EN to build in the stalled-slave bus watchdog.
module wb_rr_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    wb_rr_arbiter_if.arb  bus
);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT out of range 2..65535");
    end

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0] ERR  = 2'b10;
`endif

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] gnt;
    logic [3:0] gnt_nxt;
    logic [1:0] last;
    logic [1:0] last_nxt;

    logic [1:0] g_idx;
    logic [1:0] pick_idx;
    logic       pick_vld;
    logic       busy;
    logic       own_cyc;
    logic       own_stb;

    // Index of the current owner, decoded from the one-hot grant.
    always_comb begin
        g_idx = 2'd0;
        case (gnt)
            4'b0010: g_idx = 2'd1;
            4'b0100: g_idx = 2'd2;
            4'b1000: g_idx = 2'd3;
            default: g_idx = 2'd0;
        endcase
    end

    assign busy    = (state == BUSY);
    assign own_cyc = bus.m_cyc_i[g_idx];
    assign own_stb = bus.m_stb_i[g_idx];

    // Round-robin search starting just after the previous owner.
    always_comb begin
        logic [1:0] cand;
        pick_vld = 1'b0;
        pick_idx = last;
        cand     = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!pick_vld && bus.m_cyc_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        stall;
    logic        expire;

    // A stalled strobe is one the slave has not acked yet.
    assign stall  = busy & own_cyc & own_stb & ~bus.s_ack_i;
    // Counter reaches TIMEOUT-1 on the same edge the FSM enters ERR.
    assign expire = stall & (cnt == 16'(TIMEOUT - 2));

    // Watchdog counts stalled beats and clears on ack, idle strobe or exit.
    always_comb begin
        cnt_nxt = '0;
        if (stall) begin
            cnt_nxt = cnt + 16'd1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`endif

    // Arbitration FSM next-state logic.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                    gnt_nxt   = 4'b0001 << pick_idx;
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    last_nxt  = g_idx;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (expire) begin
                    state_nxt = ERR;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ERR: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                last_nxt  = g_idx;
            end
`endif
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State, grant and last-owner registers; master 0 wins first after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= 2'd3;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end

    // Slave-side request fields follow the owner only while BUSY.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        if (busy) begin
            bus.s_cyc_o = own_cyc;
            bus.s_stb_o = own_stb;
            bus.s_we_o  = bus.m_we_i[g_idx];
            bus.s_adr_o = bus.m_adr_i[{g_idx, 5'd0} +: 32];
            bus.s_dat_o = bus.m_dat_i[{g_idx, 5'd0} +: 32];
            bus.s_sel_o = bus.m_sel_i[{g_idx, 2'd0} +: 4];
        end
    end

    // Master-side responses: ack only to the owner, error only from ERR.
    always_comb begin
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        if (busy) begin
            bus.m_ack_o = gnt & {4{bus.s_ack_i & own_cyc}};
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (state == ERR) begin
            bus.m_err_o = gnt;
        end
`endif
    end

    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.gnt_o   = gnt;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: vector table plus watchdog/reset sequences.
// Works with and without WB_ARB_TIMEOUT_EN (TIMEOUT fixed to 8).
module tb_wb_rr_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    wb_rr_arbiter_if bus ();

    wb_rr_arbiter #(
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cyc;
        logic [3:0]  stb;
        logic [3:0]  we;
        logic        ack;
        logic [31:0] dat;
        logic [3:0]  e_gnt;
        logic [3:0]  e_ack;
        logic        e_cyc;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] adr_c[4];
    logic [31:0] dat_c[4];
    logic [3:0]  sel_c[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] cyc, input logic [3:0] stb,
                       input logic [3:0] we, input logic ack,
                       input logic [31:0] dat, input logic [3:0] e_gnt,
                       input logic [3:0] e_ack, input logic e_cyc);
        vec_t v;
        v.cyc   = cyc;
        v.stb   = stb;
        v.we    = we;
        v.ack   = ack;
        v.dat   = dat;
        v.e_gnt = e_gnt;
        v.e_ack = e_ack;
        v.e_cyc = e_cyc;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cyc, input logic [3:0] stb,
                         input logic [3:0] we, input logic ack);
        bus.m_cyc_i = cyc;
        bus.m_stb_i = stb;
        bus.m_we_i  = we;
        bus.s_ack_i = ack;
    endtask

    initial begin
        int          errs;
        int          idx;
        logic        e_stb;
        logic        e_we;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic [3:0]  e_sel;
        vec_t        v;

        total = 0;
        bad   = 0;

        for (int i = 0; i < 4; i++) begin
            adr_c[i] = 32'h4000_0000 + 32'(i) * 32'h0001_0010;
            dat_c[i] = 32'hD0D0_0000 | 32'(i);
            sel_c[i] = 4'(i + 1) ^ 4'hC;
            bus.m_adr_i[32*i +: 32] = adr_c[i];
            bus.m_dat_i[32*i +: 32] = dat_c[i];
            bus.m_sel_i[4*i +: 4]   = sel_c[i];
        end

        // cyc, stb, we, ack, s_dat, exp gnt, exp ack, exp s_cyc
        add(4'hF, 4'hF, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'hF, 4'hF, 4'h0, 1'b1, 32'h1111_0000, 4'h1, 4'h1, 1'b1);
        add(4'hE, 4'hE, 4'h0, 1'b0, 32'h0,         4'h1, 4'h0, 1'b0);
        add(4'hE, 4'hE, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'hE, 4'hE, 4'h0, 1'b1, 32'h2222_0000, 4'h2, 4'h2, 1'b1);
        add(4'hC, 4'hC, 4'h0, 1'b0, 32'h0,         4'h2, 4'h0, 1'b0);
        add(4'hC, 4'hC, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'hC, 4'hC, 4'h0, 1'b1, 32'h3333_0000, 4'h4, 4'h4, 1'b1);
        add(4'h8, 4'h8, 4'h0, 1'b0, 32'h0,         4'h4, 4'h0, 1'b0);
        add(4'h8, 4'h8, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'h8, 4'h8, 4'h0, 1'b1, 32'h4444_0000, 4'h8, 4'h8, 1'b1);
        add(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,         4'h8, 4'h0, 1'b0);
        add(4'h0, 4'h0, 4'h0, 1'b1, 32'h5555_0000, 4'h0, 4'h0, 1'b0);
        add(4'h4, 4'h4, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'h4, 4'h4, 4'h0, 1'b1, 32'hA5A5_0000, 4'h4, 4'h4, 1'b1);
        add(4'h4, 4'h4, 4'h0, 1'b1, 32'hA5A5_0001, 4'h4, 4'h4, 1'b1);
        add(4'h4, 4'h4, 4'h0, 1'b1, 32'hA5A5_0002, 4'h4, 4'h4, 1'b1);
        add(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,         4'h4, 4'h0, 1'b0);
        add(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'h2, 4'h2, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'hB, 4'h2, 4'h0, 1'b1, 32'h6666_0000, 4'h2, 4'h2, 1'b1);
        add(4'h9, 4'h9, 4'h0, 1'b0, 32'h0,         4'h2, 4'h0, 1'b0);
        add(4'h9, 4'h9, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'h9, 4'h9, 4'h0, 1'b1, 32'h7777_0000, 4'h8, 4'h8, 1'b1);
        add(4'h1, 4'h1, 4'h0, 1'b0, 32'h0,         4'h8, 4'h0, 1'b0);
        add(4'h1, 4'h1, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);
        add(4'h1, 4'h1, 4'h1, 1'b1, 32'h8888_0000, 4'h1, 4'h1, 1'b1);
        add(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,         4'h1, 4'h0, 1'b0);
        add(4'h0, 4'h0, 4'h0, 1'b0, 32'h0,         4'h0, 4'h0, 1'b0);

        // Reset held with requests and a spurious ack present.
        rst = 1'b0;
        drive(4'hF, 4'hF, 4'hF, 1'b1);
        bus.s_dat_i = 32'h0;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
        chk("rst_scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("rst_sstb", 32'(bus.s_stb_o), 32'h0);
        chk("rst_swe", 32'(bus.s_we_o), 32'h0);
        chk("rst_ack", 32'(bus.m_ack_o), 32'h0);
        chk("rst_err", 32'(bus.m_err_o), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.cyc, v.stb, v.we, v.ack);
            bus.s_dat_i = v.dat;
            @(negedge clk);
            e_stb = 1'b0;
            e_we  = 1'b0;
            e_adr = '0;
            e_dat = '0;
            e_sel = '0;
            if (v.e_gnt != 4'h0) begin
                idx = 0;
                for (int k = 0; k < 4; k++) begin
                    if (v.e_gnt[k]) idx = k;
                end
                e_stb = v.stb[idx];
                e_we  = v.we[idx];
                e_adr = adr_c[idx];
                e_dat = dat_c[idx];
                e_sel = sel_c[idx];
            end
            chk($sformatf("row%0d_gnt", i), 32'(bus.gnt_o), 32'(v.e_gnt));
            chk($sformatf("row%0d_ack", i), 32'(bus.m_ack_o), 32'(v.e_ack));
            chk($sformatf("row%0d_scyc", i), 32'(bus.s_cyc_o), 32'(v.e_cyc));
            chk($sformatf("row%0d_sstb", i), 32'(bus.s_stb_o), 32'(e_stb));
            chk($sformatf("row%0d_swe", i), 32'(bus.s_we_o), 32'(e_we));
            chk($sformatf("row%0d_sadr", i), bus.s_adr_o, e_adr);
            chk($sformatf("row%0d_sdat", i), bus.s_dat_o, e_dat);
            chk($sformatf("row%0d_ssel", i), 32'(bus.s_sel_o), 32'(e_sel));
            chk($sformatf("row%0d_mdat", i), bus.m_dat_o, v.dat);
            chk($sformatf("row%0d_err", i), 32'(bus.m_err_o), 32'h0);
            tick();
        end

        // Master 0 strobes into a slave that never acks.
        drive(4'h1, 4'h1, 4'h0, 1'b0);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        errs = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (bus.s_cyc_o !== 1'b1 || bus.m_err_o !== 4'h0) errs++;
            tick();
        end
        chk("wd_hold", 32'(errs), 32'h0);
        @(negedge clk);
        chk("wd_err", 32'(bus.m_err_o), 32'h1);
        chk("wd_scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("wd_sstb", 32'(bus.s_stb_o), 32'h0);
        chk("wd_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        @(negedge clk);
        chk("wd_idle_gnt", 32'(bus.gnt_o), 32'h0);
        chk("wd_idle_err", 32'(bus.m_err_o), 32'h0);
        tick();
        for (int c = 1; c <= 6; c++) tick();
        bus.s_ack_i = 1'b1;
        @(negedge clk);
        chk("wd_race_ack", 32'(bus.m_ack_o), 32'h1);
        chk("wd_race_err", 32'(bus.m_err_o), 32'h0);
        tick();
        bus.s_ack_i = 1'b0;
        @(negedge clk);
        chk("wd_race_scyc", 32'(bus.s_cyc_o), 32'h1);
        chk("wd_race_err2", 32'(bus.m_err_o), 32'h0);
        tick();
`else
        errs = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.s_cyc_o !== 1'b1 || bus.m_err_o !== 4'h0 ||
                bus.gnt_o !== 4'h1) errs++;
            tick();
        end
        chk("stall_hold", 32'(errs), 32'h0);
`endif
        drive(4'h0, 4'h0, 4'h0, 1'b0);
        tick();
        @(negedge clk);
        chk("stall_release", 32'(bus.gnt_o), 32'h0);

        // Reset in the middle of a master 2 write.
        drive(4'h4, 4'h4, 4'h4, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("mid_gnt", 32'(bus.gnt_o), 32'h4);
        chk("mid_swe", 32'(bus.s_we_o), 32'h1);
        #2;
        rst = 1'b0;
        bus.s_ack_i = 1'b1;
        #1;
        chk("mid_rst_scyc", 32'(bus.s_cyc_o), 32'h0);
        chk("mid_rst_sstb", 32'(bus.s_stb_o), 32'h0);
        chk("mid_rst_gnt", 32'(bus.gnt_o), 32'h0);
        chk("mid_rst_ack", 32'(bus.m_ack_o), 32'h0);
        chk("mid_rst_err", 32'(bus.m_err_o), 32'h0);
        drive(4'h5, 4'h5, 4'h0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(bus.gnt_o), 32'h0);
        tick();
        @(negedge clk);
        chk("post_rst_gnt", 32'(bus.gnt_o), 32'h1);
        chk("post_rst_scyc", 32'(bus.s_cyc_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, bus-timeout limit in clk cycles (range 2..65535).
REQ-002 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have m_cyc_i  input  4  per-master Wishbone cycle request, bit i = master i.
REQ-005 SHALL have m_stb_i  input  4  per-master strobe.
REQ-006 SHALL have m_we_i  input  4  per-master write enable.
REQ-007 SHALL have m_adr_i  input  128  master i address in bits [32i+31:32i].
REQ-008 SHALL have m_dat_i  input  128  master i write data in bits [32i+31:32i].
REQ-009 SHALL have m_sel_i  input  16  master i byte select in bits [4i+3:4i].
REQ-010 SHALL have m_dat_o  output  32  read data, s_dat_i broadcast to all masters.
REQ-011 SHALL have m_ack_o  output  4  per-master acknowledge.
REQ-012 SHALL have m_err_o  output  4  per-master bus-timeout error.
REQ-013 SHALL have s_adr_o, s_dat_o, s_sel_o, s_we_o  output  32/32/4/1  shared slave-side request fields.
REQ-014 SHALL have s_cyc_o, s_stb_o  output  1/1  shared slave cycle and strobe.
REQ-015 SHALL have s_dat_i, s_ack_i  input  32/1  slave read data and acknowledge.
REQ-016 SHALL have gnt_o  output  4  one-hot registered current grant; 0 when no owner.

Function
REQ-017 SHALL implement states IDLE, BUSY and, with the macro, ERR; state and grant registered.
REQ-018 IDLE: when any m_cyc_i bit is set, SHALL select the first requester searching from (last+1) mod 4 upward with wrap, register it as grant and enter BUSY at the next edge.
REQ-019 Grant latency SHALL be exactly one cycle: request first seen in cycle N gives s_cyc_o=1 in cycle N+1.
REQ-020 In IDLE SHALL drive s_cyc_o=0, s_stb_o=0, s_we_o=0, gnt_o=0, m_ack_o=0, m_err_o=0.
REQ-021 BUSY: s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o SHALL be the granted master's fields combinationally.
REQ-022 BUSY: m_ack_o[g] SHALL equal s_ack_i & m_cyc_i[g] combinationally; all other ack bits 0.
REQ-023 Grant SHALL persist across any number of stb/ack beats while m_cyc_i[g]=1, including back-to-back transfers and locked sequences.
REQ-024 When m_cyc_i[g]=0 in BUSY, SHALL store last=g and return to IDLE; one IDLE cycle always separates consecutive grants, even if another master requests in the same cycle.
REQ-025 Requests from non-granted masters SHALL be ignored (no ack, no err) until re-arbitration.
REQ-026 s_ack_i asserted in IDLE SHALL be ignored.

Reset
REQ-027 rst=0 SHALL asynchronously force state IDLE, grant 0, last=3 (master 0 wins first), timeout counter 0, and all outputs to IDLE values from REQ-020.
REQ-028 Reset asserted mid-transfer SHALL drop s_cyc_o/s_stb_o in the same cycle without any ack or err pulse.
REQ-029 After rst returns to 1, arbitration SHALL start on the first rising edge.

Configuration
REQ-030 Macro WB_ARB_TIMEOUT_EN SHALL compile in the bus watchdog.
REQ-031 With WB_ARB_TIMEOUT_EN: a 16-bit counter SHALL increment each BUSY cycle with s_stb_o=1 and s_ack_i=0 and clear on ack, on stb low, or on leaving BUSY.
REQ-032 With WB_ARB_TIMEOUT_EN: when the counter equals TIMEOUT-1 without ack, the FSM SHALL enter ERR, drive m_err_o[g]=1 and s_cyc_o=s_stb_o=0 for exactly one cycle, store last=g, then go to IDLE.
REQ-033 With WB_ARB_TIMEOUT_EN: an ack arriving in the same cycle the limit is reached SHALL take precedence (normal ack, no ERR).
REQ-034 Without WB_ARB_TIMEOUT_EN: no counter and no ERR state SHALL exist, m_err_o SHALL be constant 0, and a stalled slave holds the grant indefinitely.

Verification
REQ-035 Reset release, m_cyc_i=4'b1111 held -> gnt_o sequence 0001,0000,0010,0000,0100,0000,1000 as each master completes one acked beat and drops cyc.
REQ-036 Master 2 alone, 3 back-to-back reads, slave acks each cycle with s_dat_i=0xA5A50000+n -> one grant, m_ack_o=4'b0100 for 3 cycles, m_dat_o matches, no IDLE gap between beats.
REQ-037 Master 1 in BUSY; master 0 and master 3 request; master 1 drops cyc -> one IDLE cycle, then grant to master 3 (searched from 2).
REQ-038 WB_ARB_TIMEOUT_EN, TIMEOUT=8, master 0 strobes, slave never acks -> m_err_o=4'b0001 for one cycle at BUSY cycle 8, s_cyc_o=0 that cycle, IDLE next; without macro -> s_cyc_o stays 1 for 100 cycles.
REQ-039 rst pulled low mid-write of master 2 -> s_cyc_o=0 and gnt_o=0 immediately; after release with m_cyc_i=4'b0101, master 0 is granted first.
